// File: rtl/run_length_tx.sv
// run_length_tx -- serial run-length transmitter.
//
// Each accepted nonzero 2-bit symbol N (1..3) is sent on the line as N mark
// bits (y=1), followed by GAP space bits (y=0). A symbol of 0 is
// accepted and dropped. A one-entry hold register decouples the producer
// from the line engine. The next symbol can be taken while a frame is on the
// line, so consecutive frames are separated by exactly GAP zeros.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   sym[1:0]   in   symbol to transmit, qualified by sym_valid
//   sym_valid  in   producer offers sym
//   sym_ready  out  hold register empty and not in reset
//   y          out  registered serial line (1 = mark, 0 = space/idle)
//   busy       out  engine not idle or hold register full
//   sent_cnt   out  registered modulo-256 count of completed frames
module run_length_tx #(
  parameter int unsigned GAP = 1  // space bits after each frame, 1..7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       y,
  output logic       busy,
  output logic [7:0] sent_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ONES,
    ST_GAP
  } state_e;

  localparam logic [2:0] GAP_LOAD = 3'(GAP);

  state_e     state_q, state_d;
  logic       hold_full_q, hold_full_d;
  logic [1:0] hold_q, hold_d;
  logic [1:0] run_q, run_d;      // mark bits still to send, including this one
  logic [2:0] gap_q, gap_d;      // space bits still to send, including this one
  logic       y_q, y_d;
  logic [7:0] sent_cnt_q, sent_cnt_d;

  logic accept;

  assign sym_ready = ~hold_full_q & ~rst;
  assign accept    = sym_valid & sym_ready;
  assign y         = y_q;
  assign busy      = (state_q != ST_IDLE) | hold_full_q;
  assign sent_cnt  = sent_cnt_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    run_d       = run_q;
    gap_d       = gap_q;
    y_d         = 1'b0;
    sent_cnt_d  = sent_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d     = ST_ONES;
          run_d       = hold_q;
          hold_full_d = 1'b0;
          y_d         = 1'b1;
        end
      end
      ST_ONES: begin
        if (run_q == 2'd1) begin
          state_d    = ST_GAP;
          gap_d      = GAP_LOAD;
          sent_cnt_d = sent_cnt_q + 8'd1;
        end else begin
          run_d = run_q - 2'd1;
          y_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == 3'd1) begin
          if (hold_full_q) begin
            state_d     = ST_ONES;
            run_d       = hold_q;
            hold_full_d = 1'b0;
            y_d         = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A handshake only happens while the hold register is empty, so it can
    // never coincide with the engine emptying it above.
    if (accept && (sym != 2'b00)) begin
      hold_full_d = 1'b1;
      hold_d      = sym;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values computed before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset clears everything, including a held symbol, so a frame
      // interrupted by reset is abandoned rather than resumed.
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= 2'b00;
      run_q       <= 2'b00;
      gap_q       <= 3'b000;
      y_q         <= 1'b0;
      sent_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      run_q       <= run_d;
      gap_q       <= gap_d;
      y_q         <= y_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

endmodule

// File: tb/tb_run_length_tx.sv
// Testbench for run_length_tx: directed scenarios on a GAP=1 instance and a
// GAP=3 instance, with hand-computed expected line sequences.
module tb_run_length_tx;

  logic       clk = 1'b0;

  // GAP = 1 instance
  logic       rst = 1'b1;
  logic [1:0] sym = 2'b00;
  logic       sym_valid = 1'b0;
  logic       sym_ready, y, busy;
  logic [7:0] sent_cnt;

  // GAP = 3 instance
  logic       rst3 = 1'b1;
  logic [1:0] sym3 = 2'b00;
  logic       sym_valid3 = 1'b0;
  logic       sym_ready3, y3, busy3;
  logic [7:0] sent_cnt3;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_sent = 8'd0;

  always #5 clk = ~clk;

  run_length_tx #(.GAP(1)) u_dut (
    .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .y(y), .busy(busy), .sent_cnt(sent_cnt)
  );

  run_length_tx #(.GAP(3)) u_dut3 (
    .clk(clk), .rst(rst3), .sym(sym3), .sym_valid(sym_valid3),
    .sym_ready(sym_ready3), .y(y3), .busy(busy3), .sent_cnt(sent_cnt3)
  );

  // Advance one rising edge and settle; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sym_valid = 1'b1;  // must be ignored while in reset
    sym       = 2'b11;
    tick();
    tick();
    total_cnt++;
    if (sym_ready !== 1'b0) $display("FAIL reset_ready_in_rst got=%b exp=0", sym_ready);
    else pass_cnt++;
    total_cnt++;
    if (y !== 1'b0) $display("FAIL reset_y got=%b exp=0", y);
    else pass_cnt++;
    total_cnt++;
    if (sent_cnt !== 8'd0) $display("FAIL reset_sent got=%0d exp=0", sent_cnt);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else pass_cnt++;
    sym_valid = 1'b0;
    rst  = 1'b0;
    rst3 = 1'b0;
    #1;
    total_cnt++;
    if (sym_ready !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", sym_ready);
    else pass_cnt++;
    total_cnt++;
    if (sym_ready3 !== 1'b1) $display("FAIL reset_ready3_after got=%b exp=1", sym_ready3);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [0:4] y_exp = 5'b01100;  // from the acceptance edge, then idle
    logic [0:4] r_exp = 5'b01111;
    sym       = 2'b10;
    sym_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      sym_valid = 1'b0;
      total_cnt++;
      if (y !== y_exp[i]) $display("FAIL single_y[%0d] got=%b exp=%b", i, y, y_exp[i]);
      else pass_cnt++;
      total_cnt++;
      if (sym_ready !== r_exp[i]) $display("FAIL single_ready[%0d] got=%b exp=%b", i, sym_ready, r_exp[i]);
      else pass_cnt++;
    end
    exp_sent = exp_sent + 8'd1;
    total_cnt++;
    if (sent_cnt !== exp_sent) $display("FAIL single_sent got=%0d exp=%0d", sent_cnt, exp_sent);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", busy);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    sym       = 2'b00;
    sym_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({sym_ready, y, busy} !== 3'b100)
        $display("FAIL zero[%0d] ready/y/busy got=%b exp=100", i, {sym_ready, y, busy});
      else pass_cnt++;
    end
    sym_valid = 1'b0;
    total_cnt++;
    if (sent_cnt !== exp_sent) $display("FAIL zero_sent got=%0d exp=%0d", sent_cnt, exp_sent);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [0:5] y_exp = 6'b101110;  // after edges t+1 .. t+6
    sym       = 2'b01;
    sym_valid = 1'b1;
    tick();  // 01 accepted
    sym = 2'b11;
    total_cnt++;
    if (sym_ready !== 1'b0) $display("FAIL b2b_ready_full got=%b exp=0", sym_ready);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) sym_valid = 1'b0;  // 11 accepted on this edge
      total_cnt++;
      if (y !== y_exp[i]) $display("FAIL b2b_y[%0d] got=%b exp=%b", i, y, y_exp[i]);
      else pass_cnt++;
    end
    tick();
    exp_sent = exp_sent + 8'd2;
    total_cnt++;
    if (sent_cnt !== exp_sent) $display("FAIL b2b_sent got=%0d exp=%0d", sent_cnt, exp_sent);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_busy got=%b exp=0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    sym       = 2'b11;
    sym_valid = 1'b1;
    tick();  // accepted
    sym_valid = 1'b0;
    tick();  // first mark
    tick();  // second mark
    total_cnt++;
    if (y !== 1'b1) $display("FAIL midrst_second_mark got=%b exp=1", y);
    else pass_cnt++;
    rst       = 1'b1;
    sym_valid = 1'b1;  // ignored during reset
    sym       = 2'b01;
    #1;
    total_cnt++;
    if (sym_ready !== 1'b0) $display("FAIL midrst_ready_in_rst got=%b exp=0", sym_ready);
    else pass_cnt++;
    tick();
    rst       = 1'b0;
    sym_valid = 1'b0;
    exp_sent  = 8'd0;
    #1;
    total_cnt++;
    if ({y, busy, sym_ready} !== 3'b001)
      $display("FAIL midrst y/busy/ready got=%b exp=001", {y, busy, sym_ready});
    else pass_cnt++;
    total_cnt++;
    if (sent_cnt !== 8'd0) $display("FAIL midrst_sent got=%0d exp=0", sent_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({y, busy} !== 2'b00) $display("FAIL midrst_after y/busy got=%b exp=00", {y, busy});
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int   frames = 0;
    int   cycles = 0;
    logic prev_y = 1'b0;
    sym       = 2'b01;
    sym_valid = 1'b1;
    while (frames < 256 && cycles < 2000) begin
      tick();
      cycles++;
      if (prev_y && !y) begin
        frames++;
        if (frames == 255) begin
          total_cnt++;
          if (sent_cnt !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", sent_cnt);
          else pass_cnt++;
        end
        if (frames == 256) begin
          total_cnt++;
          if (sent_cnt !== 8'd0) $display("FAIL wrap_256 got=%0d exp=0", sent_cnt);
          else pass_cnt++;
        end
      end
      prev_y = y;
    end
    sym_valid = 1'b0;
    total_cnt++;
    if (frames != 256) $display("FAIL wrap_timeout frames=%0d exp=256", frames);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_gap3();
    logic [1:0]  syms [3] = '{2'b11, 2'b10, 2'b01};
    logic [0:15] y_exp = 16'b1110001100010000;       // after edges t+1 .. t+16
    logic [0:16] r_exp = 17'b01000001000011111;      // after edges t .. t+16
    int   idx = 0;
    logic hs;
    sym3       = syms[0];
    sym_valid3 = 1'b1;
    for (int step = 0; step <= 16; step++) begin
      hs = sym_ready3 & sym_valid3;
      tick();
      if (hs) begin
        idx++;
        if (idx < 3) sym3 = syms[idx];
        else sym_valid3 = 1'b0;
      end
      total_cnt++;
      if (sym_ready3 !== r_exp[step])
        $display("FAIL gap3_ready[%0d] got=%b exp=%b", step, sym_ready3, r_exp[step]);
      else pass_cnt++;
      if (step >= 1) begin
        total_cnt++;
        if (y3 !== y_exp[step-1])
          $display("FAIL gap3_y[%0d] got=%b exp=%b", step, y3, y_exp[step-1]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (idx != 3) $display("FAIL gap3_accepted got=%0d exp=3", idx);
    else pass_cnt++;
    total_cnt++;
    if (sent_cnt3 !== 8'd3) $display("FAIL gap3_sent got=%0d exp=3", sent_cnt3);
    else pass_cnt++;
    total_cnt++;
    if (busy3 !== 1'b0) $display("FAIL gap3_busy got=%b exp=0", busy3);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
    test_gap3();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
